// File: rtl/except_prio_flush_ctrl_pkg.sv
// Shared types and helpers for the exception priority/flush controller.
// Holds the FSM state encoding, the exception-code format and the priority pick.
package except_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] EXC_CODE_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } except_state_e;

  // Lowest set bit wins; returns 0 when nothing is set (callers qualify with |v).
  function automatic logic [CODE_W-1:0] prio_lowest(input logic [15:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/except_prio_flush_ctrl_if.sv
// Pipeline-side signal bundle of the exception controller.
// The master drives requests and stage PCs; the slave (controller) drives status.
interface except_prio_flush_ctrl_if
  import except_pkg::*;
#(
  parameter int NUM_EXC = 14,
  parameter int PC_W    = 32
);
  logic [NUM_EXC-1:0] except_trig;
  logic [NUM_EXC-1:0] except_en;
  logic               flush_freeze;
  logic               if_stall;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    ex_pc;
  logic [PC_W-1:0]    wb_pc;
  logic               ex_dslot;
  logic               except_flushpipe;
  logic [CODE_W-1:0]  except_type;
  logic [PC_W-1:0]    epcr;
  logic               except_busy;
  logic [NUM_EXC-1:0] pending;

  modport master (
    output except_trig, except_en, flush_freeze, if_stall,
    output id_pc, ex_pc, wb_pc, ex_dslot,
    input  except_flushpipe, except_type, epcr, except_busy, pending
  );

  modport slave (
    input  except_trig, except_en, flush_freeze, if_stall,
    input  id_pc, ex_pc, wb_pc, ex_dslot,
    output except_flushpipe, except_type, epcr, except_busy, pending
  );
endinterface

// File: rtl/except_prio_flush_ctrl_prio_enc.sv
// Fixed-priority encoder: index 0 has highest priority.
module except_prio_enc
  import except_pkg::*;
#(
  parameter int N = 14
) (
  input  logic [N-1:0]      req_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] idx_o
);
  assign valid_o = |req_i;
  assign idx_o   = prio_lowest(16'(req_i));
endmodule

// File: rtl/except_prio_flush_ctrl.sv
// Exception controller: arbitrates sticky requests, captures EPCR, and sequences
// the pipeline flush (FLUSH count-down, then WAIT for fetch) before release.
module except_prio_flush_ctrl
  import except_pkg::*;
#(
  parameter int          NUM_EXC     = 14,
  parameter int          PC_W        = 32,
  parameter int          FLUSH_DEPTH = 5,
  parameter logic [15:0] ID_PC_MASK  = 16'h3000,
  parameter logic [15:0] SHORT_MASK  = 16'h2000
) (
  input  logic                    clk,
  input  logic                    reset,
  except_prio_flush_ctrl_if.slave bus
);
  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  except_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  type_q, type_d;
  logic [PC_W-1:0]    epcr_q, epcr_d;
  logic [NUM_EXC-1:0] pend_q, pend_d;
  logic               flush_q;

  logic [NUM_EXC-1:0] req;
  logic [NUM_EXC-1:0] win_oh;
  logic               win_valid;
  logic [CODE_W-1:0]  win_idx;
  logic [CODE_W-1:0]  short_idx;
  logic               take;

  assign req = (pend_q | bus.except_trig) & bus.except_en;

  except_prio_enc #(.N(NUM_EXC)) u_prio (
    .req_i   (req),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  assign take      = (state_q == ST_IDLE) && win_valid;
  assign win_oh    = take ? (NUM_EXC'(1) << win_idx) : '0;
  // The winner's own trigger in the take cycle is consumed, never re-pended.
  assign pend_d    = (pend_q | bus.except_trig) & ~win_oh;
  assign short_idx = type_q - CODE_W'(1);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    epcr_d  = epcr_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_FLUSH;
          type_d  = win_idx + CODE_W'(1);
          cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          if (bus.ex_dslot)           epcr_d = bus.wb_pc;
          else if (ID_PC_MASK[win_idx]) epcr_d = bus.id_pc;
          else                        epcr_d = bus.ex_pc;
        end
      end
      ST_FLUSH: begin
        if (SHORT_MASK[short_idx]) begin
          state_d = ST_IDLE;
          type_d  = EXC_CODE_NONE;
        end else if (cnt_q == '0) begin
          state_d = ST_WAIT;
        end else if (!bus.flush_freeze) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.if_stall) begin
          state_d = ST_IDLE;
          type_d  = EXC_CODE_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        type_d  = EXC_CODE_NONE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= EXC_CODE_NONE;
      epcr_q  <= '0;
      pend_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      epcr_q  <= epcr_d;
      pend_q  <= pend_d;
      flush_q <= take;
    end
  end

  assign bus.except_flushpipe = flush_q;
  assign bus.except_type      = type_q;
  assign bus.epcr             = epcr_q;
  assign bus.except_busy      = (state_q != ST_IDLE);
  assign bus.pending          = pend_q;

endmodule

// File: tb/tb_except_prio_flush_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// cycle-level behavioural model compared against the DUT on every falling edge.
module tb_except_prio_flush_ctrl;
  import except_pkg::*;

  localparam int NUM_EXC     = 14;
  localparam int PC_W        = 32;
  localparam int FLUSH_DEPTH = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  except_prio_flush_ctrl_if #(.NUM_EXC(NUM_EXC), .PC_W(PC_W)) bus ();

  except_prio_flush_ctrl #(
    .NUM_EXC     (NUM_EXC),
    .PC_W        (PC_W),
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .ID_PC_MASK  (16'h3000),
    .SHORT_MASK  (16'h2000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no exception in service, 1 = flushing, 2 = waiting for fetch.
  logic [NUM_EXC-1:0] m_pend;
  logic [NUM_EXC-1:0] m_req;
  logic [NUM_EXC-1:0] m_nxt;
  logic [PC_W-1:0]    m_epcr;
  logic               m_fp;
  int                 m_code, m_phase, m_left, m_win;

  function automatic bit src_uses_id_pc(input int src);
    return (src == 12) || (src == 13);
  endfunction

  function automatic bit src_is_short(input int src);
    return src == 13;
  endfunction

  initial begin
    m_pend = '0; m_epcr = '0; m_fp = 1'b0; m_code = 0; m_phase = 0; m_left = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pend = '0; m_epcr = '0; m_fp = 1'b0; m_code = 0; m_phase = 0; m_left = 0;
      end else begin
        m_req = (m_pend | bus.except_trig) & bus.except_en;
        m_win = -1;
        for (int i = NUM_EXC - 1; i >= 0; i--) if (m_req[i]) m_win = i;
        m_nxt = m_pend | bus.except_trig;
        m_fp  = 1'b0;
        if (m_phase == 0) begin
          if (m_win >= 0) begin
            m_nxt[m_win] = 1'b0;
            m_fp    = 1'b1;
            m_phase = 1;
            m_code  = m_win + 1;
            m_left  = FLUSH_DEPTH - 1;
            m_epcr  = bus.ex_dslot ? bus.wb_pc :
                      src_uses_id_pc(m_win) ? bus.id_pc : bus.ex_pc;
          end
        end else if (m_phase == 1) begin
          if (src_is_short(m_code - 1)) begin
            m_phase = 0; m_code = 0;
          end else if (m_left == 0) begin
            m_phase = 2;
          end else if (!bus.flush_freeze) begin
            m_left = m_left - 1;
          end
        end else if (!bus.if_stall) begin
          m_phase = 0; m_code = 0;
        end
        m_pend = m_nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("model_flushpipe", 64'(bus.except_flushpipe), 64'(m_fp));
      check("model_type",      64'(bus.except_type),      64'(m_code));
      check("model_epcr",      64'(bus.epcr),             64'(m_epcr));
      check("model_busy",      64'(bus.except_busy),      64'(m_phase != 0));
      check("model_pending",   64'(bus.pending),          64'(m_pend));
    end
  end

  // ---------------- directed stimulus ----------------
  // Counts busy falling edges from the current one until idle; at busy edge
  // number rel_at, freeze and stall are released.
  task automatic count_busy(input int rel_at, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.except_busy) break;
      n++;
      if (n == rel_at) begin
        bus.flush_freeze = 1'b0;
        bus.if_stall     = 1'b0;
      end
      @(negedge clk);
    end
    check("idle_timeout", 64'(bus.except_busy), 64'(0));
  endtask

  function automatic logic [NUM_EXC-1:0] bitv(input int i);
    logic [NUM_EXC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  int n;

  initial begin
    reset = 1'b0;
    bus.except_trig = '0; bus.except_en = '1;
    bus.flush_freeze = 1'b0; bus.if_stall = 1'b0;
    bus.id_pc = '0; bus.ex_pc = '0; bus.wb_pc = '0; bus.ex_dslot = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_type",    64'(bus.except_type), 64'(0));
    check("rst_epcr",    64'(bus.epcr), 64'(0));
    check("rst_pending", 64'(bus.pending), 64'(0));
    check("rst_busy",    64'(bus.except_busy), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single take, source 6.
    bus.except_trig = bitv(6);
    bus.ex_pc = 32'h100; bus.id_pc = 32'h200; bus.wb_pc = 32'h300;
    @(negedge clk);
    bus.except_trig = '0;
    check("t2_flushpipe", 64'(bus.except_flushpipe), 64'(1));
    check("t2_type",      64'(bus.except_type), 64'(7));
    check("t2_epcr",      64'(bus.epcr), 64'(32'h100));
    count_busy(0, n);
    check("t2_busy_cycles", 64'(n), 64'(6));
    check("t2_type_idle",   64'(bus.except_type), 64'(0));

    // Priority: sources 2 and 9 together.
    bus.except_trig = bitv(2) | bitv(9);
    @(negedge clk);
    bus.except_trig = '0;
    check("t3_type_first", 64'(bus.except_type), 64'(3));
    check("t3_pend9",      64'(bus.pending[9]), 64'(1));
    count_busy(0, n);
    @(negedge clk);
    check("t3_type_second", 64'(bus.except_type), 64'(10));
    check("t3_pend9_clr",   64'(bus.pending[9]), 64'(0));
    count_busy(0, n);
    check("t3_busy_cycles", 64'(n), 64'(6));

    // Delay slot overrides the id_pc selection of source 12.
    bus.ex_dslot = 1'b1;
    bus.wb_pc = 32'h2FC; bus.id_pc = 32'h500; bus.ex_pc = 32'h600;
    bus.except_trig = bitv(12);
    @(negedge clk);
    bus.except_trig = '0; bus.ex_dslot = 1'b0;
    check("t4_type", 64'(bus.except_type), 64'(13));
    check("t4_epcr", 64'(bus.epcr), 64'(32'h2FC));
    count_busy(0, n);

    // Short flush on source 13 ignores freeze and stall; EPCR from id_pc.
    bus.flush_freeze = 1'b1; bus.if_stall = 1'b1; bus.id_pc = 32'h700;
    bus.except_trig = bitv(13);
    @(negedge clk);
    bus.except_trig = '0;
    check("t5_type", 64'(bus.except_type), 64'(14));
    check("t5_epcr", 64'(bus.epcr), 64'(32'h700));
    count_busy(0, n);
    check("t5_busy_cycles", 64'(n), 64'(1));
    bus.flush_freeze = 1'b0; bus.if_stall = 1'b0;

    // Masked source stays pending; enabling it with a fresh trigger gives one service.
    bus.except_en = ~bitv(4);
    bus.except_trig = bitv(4);
    @(negedge clk);
    bus.except_trig = '0;
    check("t6_pend4", 64'(bus.pending[4]), 64'(1));
    check("t6_no_take", 64'(bus.except_busy), 64'(0));
    @(negedge clk);
    check("t6_still_idle", 64'(bus.except_busy), 64'(0));
    bus.except_en = '1;
    bus.except_trig = bitv(4);
    @(negedge clk);
    bus.except_trig = '0;
    check("t6_type", 64'(bus.except_type), 64'(5));
    check("t6_pend4_clr", 64'(bus.pending[4]), 64'(0));
    count_busy(0, n);
    @(negedge clk);
    check("t6_single_service", 64'(bus.except_busy), 64'(0));

    // if_stall held for three WAIT cycles delays release by exactly three.
    bus.if_stall = 1'b1;
    bus.except_trig = bitv(0);
    @(negedge clk);
    bus.except_trig = '0;
    check("t6b_type", 64'(bus.except_type), 64'(1));
    count_busy(9, n);
    check("t6b_busy_cycles", 64'(n), 64'(9));

    // Two frozen cycles while counting extend the flush by two.
    bus.except_trig = bitv(1);
    @(negedge clk);
    bus.except_trig = '0;
    bus.flush_freeze = 1'b1;
    check("t7_type", 64'(bus.except_type), 64'(2));
    count_busy(3, n);
    check("t7_busy_cycles", 64'(n), 64'(8));

    // Reset in the middle of FLUSH clears everything at once, pending included.
    bus.ex_pc = 32'h6000;
    bus.except_en = ~bitv(5);
    bus.except_trig = bitv(3) | bitv(5);
    @(negedge clk);
    bus.except_trig = '0;
    check("t1_type", 64'(bus.except_type), 64'(4));
    check("t1_pend5", 64'(bus.pending[5]), 64'(1));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_rst_type",    64'(bus.except_type), 64'(0));
    check("t1_rst_epcr",    64'(bus.epcr), 64'(0));
    check("t1_rst_pending", 64'(bus.pending), 64'(0));
    check("t1_rst_busy",    64'(bus.except_busy), 64'(0));
    check("t1_rst_fp",      64'(bus.except_flushpipe), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    bus.except_en = '1;
    repeat (2) @(negedge clk);
    check("t1_pending_lost", 64'(bus.except_busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
